// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses pll_rst, qualifies lock, releases sys_rst_n, retries, then fails.
// Optional feature macro: LOCK_LOSS_CNT_EN adds the lock_loss_cnt output.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int MAX_RETRIES      = 4
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        pll_locked,
    input  logic        relock_req,
    output logic        pll_rst,
    output logic        sys_rst_n,
    output logic        ready,
    output logic        fail,
    output logic [3:0]  retry_cnt
`ifdef LOCK_LOSS_CNT_EN
    ,
    output logic [15:0] lock_loss_cnt
`endif
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYC - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYC - 1);
    // The WAIT_LOCK cycle that first sees lock is the first of the stable run
    localparam logic [CW-1:0] STB_LAST = CW'((LOCK_STABLE_CYC > 1) ? LOCK_STABLE_CYC - 2 : 0);
    localparam logic [3:0]    MAX_R    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [1:0]    sync_r;
    logic          lk_s;
    logic [CW-1:0] cnt_r;
    logic [3:0]    retry_nx_s;
    logic          reload_s;

    assign lk_s = sync_r[1];

    // two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], pll_locked};
        end
    end

    // next-state and retry bookkeeping; relock_req overrides every other event
    always_comb begin
        state_nx_s = state_r;
        retry_nx_s = retry_cnt;
        if (relock_req) begin
            state_nx_s = ST_RESET_PLL;
            retry_nx_s = 4'd0;
        end else begin
            case (state_r)
                ST_RESET_PLL: begin
                    if (cnt_r == RST_LAST) begin
                        state_nx_s = ST_WAIT_LOCK;
                    end else begin
                        state_nx_s = ST_RESET_PLL;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk_s) begin
                        if (LOCK_STABLE_CYC == 1) begin
                            state_nx_s = ST_RUN;
                            retry_nx_s = 4'd0;
                        end else begin
                            state_nx_s = ST_STABLE;
                        end
                    end else if (cnt_r == TO_LAST) begin
                        retry_nx_s = (retry_cnt == 4'd15) ? 4'd15 : retry_cnt + 4'd1;
                        if (retry_cnt >= MAX_R) begin
                            state_nx_s = ST_FAIL;
                        end else begin
                            state_nx_s = ST_RESET_PLL;
                        end
                    end else begin
                        state_nx_s = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    if (!lk_s) begin
                        state_nx_s = ST_WAIT_LOCK;
                    end else if (cnt_r == STB_LAST) begin
                        state_nx_s = ST_RUN;
                        retry_nx_s = 4'd0;
                    end else begin
                        state_nx_s = ST_STABLE;
                    end
                end
                ST_RUN: begin
                    if (!lk_s) begin
                        state_nx_s = ST_RESET_PLL;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    state_nx_s = ST_FAIL;
                end
                default: begin
                    state_nx_s = ST_RESET_PLL;
                end
            endcase
        end
    end

    // any state entry, including a relock re-entry of RESET_PLL, restarts the cycle count
    always_comb begin
        reload_s = (state_nx_s != state_r) || relock_req;
    end

    // state, cycle counter and registered outputs derived from the next state
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RESET_PLL;
            cnt_r     <= '0;
            retry_cnt <= 4'd0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= reload_s ? '0 : cnt_r + CW'(1);
            retry_cnt <= retry_nx_s;
            pll_rst   <= (state_nx_s == ST_RESET_PLL) || (state_nx_s == ST_FAIL);
            sys_rst_n <= (state_nx_s == ST_RUN);
            ready     <= (state_nx_s == ST_RUN);
            fail      <= (state_nx_s == ST_FAIL);
        end
    end

`ifdef LOCK_LOSS_CNT_EN
    logic loss_evt_s;

    // a RUN exit counts only when lock loss, not a relock request, caused it
    always_comb begin
        loss_evt_s = (state_r == ST_RUN) && !lk_s && !relock_req;
    end

    // saturating lock-loss counter, cleared only by rst_n
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt <= 16'd0;
        end else if (loss_evt_s && (lock_loss_cnt != 16'hFFFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 16'd1;
        end else begin
            lock_loss_cnt <= lock_loss_cnt;
        end
    end
`endif

endmodule
